// File: rtl/async_to_sync_ctrl.sv
// Receiver half of the 4-phase req/ack link: captures bundled data into a small FIFO
// and presents it on a valid/ready interface. Optional status outputs: ASYNC_TO_SYNC_STATUS_EN.
module async_to_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGE = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        async_req,
    output logic                        async_ack,
    input  logic [DATA_WIDTH-1:0]       async_d,
    output logic                        sync_valid,
    input  logic                        sync_ready,
    output logic [DATA_WIDTH-1:0]       sync_d
`ifdef ASYNC_TO_SYNC_STATUS_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 xfer_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                               state, state_nxt;
    logic                                 ack_nxt;
    logic                                 req_s;
    logic                                 push, pop;
    logic [AW-1:0]                        wr_ptr, rd_ptr;
    logic [AW:0]                          count;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;

    generate
        if (SYNC_STAGE == 0) begin : g_nosync
            assign req_s = async_req;
        end else begin : g_sync
            logic [SYNC_STAGE-1:0] sync_ff;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_ff <= '0;
                end else begin
                    sync_ff[0] <= async_req;
                    for (int i = 1; i < SYNC_STAGE; i++) sync_ff[i] <= sync_ff[i-1];
                end
            end
            assign req_s = sync_ff[SYNC_STAGE-1];
        end
    endgenerate

    // Full check looks only at the registered count, so a pop frees space one edge later.
    always_comb begin
        state_nxt = state;
        ack_nxt   = async_ack;
        push      = 1'b0;
        case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                if (req_s && (count < DEPTH_C)) begin
                    push      = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                ack_nxt = 1'b1;
                if (!req_s) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            async_ack <= 1'b0;
        end else begin
            state     <= state_nxt;
            async_ack <= ack_nxt;
        end
    end

    assign sync_valid = (count != '0);
    assign sync_d     = mem[rd_ptr];
    assign pop        = sync_valid & sync_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= async_d;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ASYNC_TO_SYNC_STATUS_EN
    assign fifo_level = count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)   xfer_cnt <= '0;
        else if (pop) xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_async_to_sync_ctrl.sv
// Directed bench for async_to_sync_ctrl: vector table for the basic and full-FIFO
// handshakes, hand sequences for reset-mid-transfer and an unsynchronized streaming run.
module tb_async_to_sync_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;

    logic       req0 = 1'b0, rdy0 = 1'b0;
    logic [7:0] d0 = '0;
    logic       ack0, v0;
    logic [7:0] sd0;

    logic       req1 = 1'b0, rdy1 = 1'b0;
    logic [7:0] d1 = '0;
    logic       ack1, v1;
    logic [7:0] sd1;

`ifdef ASYNC_TO_SYNC_STATUS_EN
    logic [1:0]  lvl0, lvl1;
    logic [15:0] xc0, xc1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    async_to_sync_ctrl #(.DATA_WIDTH(8), .SYNC_STAGE(2), .FIFO_DEPTH(2)) u0 (
        .clock(clock), .reset(reset),
        .async_req(req0), .async_ack(ack0), .async_d(d0),
        .sync_valid(v0), .sync_ready(rdy0), .sync_d(sd0)
`ifdef ASYNC_TO_SYNC_STATUS_EN
        , .fifo_level(lvl0), .xfer_cnt(xc0)
`endif
    );

    async_to_sync_ctrl #(.DATA_WIDTH(8), .SYNC_STAGE(0), .FIFO_DEPTH(2)) u1 (
        .clock(clock), .reset(reset),
        .async_req(req1), .async_ack(ack1), .async_d(d1),
        .sync_valid(v1), .sync_ready(rdy1), .sync_d(sd1)
`ifdef ASYNC_TO_SYNC_STATUS_EN
        , .fifo_level(lvl1), .xfer_cnt(xc1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       req;
        logic [7:0] d;
        logic       rdy;
        logic       ack;
        logic       vld;
        logic [7:0] sd;
        logic       chk_d;
    } vec_t;

    vec_t tv[27];
    logic [7:0] rx[10];
    int nrx, ntx;
    bit seen;

    initial begin
        // rows 0-5: single A5 transfer; rows 6-26: three transfers into a 2-deep FIFO
        tv[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tv[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tv[2]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
        tv[3]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[8]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        tv[9]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        tv[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tv[12] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tv[13] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tv[14] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        tv[15] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        tv[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        tv[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tv[18] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tv[19] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tv[20] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tv[21] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tv[22] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
        tv[23] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
        tv[24] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1};
        tv[25] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[26] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ack0", ack0, 0);
        chk("rst_vld0", v0, 0);
        chk("rst_d0", sd0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_vld1", v1, 0);
`ifdef ASYNC_TO_SYNC_STATUS_EN
        chk("rst_lvl0", lvl0, 0);
        chk("rst_xc1", xc1, 0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 27; i++) begin
            req0 = tv[i].req;
            d0   = tv[i].d;
            rdy0 = tv[i].rdy;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_ack", i), ack0, tv[i].ack);
            chk($sformatf("vec%0d_vld", i), v0, tv[i].vld);
            if (tv[i].chk_d) chk($sformatf("vec%0d_d", i), sd0, tv[i].sd);
        end

        // reset while acked with one word buffered, req held high through release
        rdy0 = 1'b0;
        req0 = 1'b1;
        d0   = 8'h5A;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clock);
            #1;
            seen = ack0;
        end
        chk("rst_mid_ack_seen", seen, 1);
        chk("rst_mid_vld_pre", v0, 1);
`ifdef ASYNC_TO_SYNC_STATUS_EN
        chk("rst_mid_lvl_pre", lvl0, 1);
`endif
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_ack", ack0, 0);
        chk("rst_mid_vld", v0, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("rel_e1_ack", ack0, 0);
        @(posedge clock); #1;
        chk("rel_e2_ack", ack0, 0);
        @(posedge clock); #1;
        chk("rel_e3_ack", ack0, 1);
        chk("rel_e3_vld", v0, 1);
        chk("rel_e3_d", sd0, 8'h5A);
        req0 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rel_ack_drop", ack0, 0);
        chk("rel_one_word", v0, 1);
        rdy0 = 1'b1;
        @(posedge clock); #1;
        rdy0 = 1'b0;
        chk("rel_drained", v0, 0);

        // unsynchronized instance: 10 back-to-back transfers, ready toggling
        nrx = 0;
        ntx = 0;
        for (int cyc = 0; cyc < 300 && nrx < 10; cyc++) begin
            if (req1 && ack1) begin
                req1 = 1'b0;
            end else if (!req1 && !ack1 && ntx < 10) begin
                d1   = 8'(ntx);
                req1 = 1'b1;
                ntx++;
            end
            rdy1 = ~rdy1;
            if (v1 && rdy1) begin
                rx[nrx] = sd1;
                nrx++;
            end
            @(posedge clock);
            #1;
        end
        req1 = 1'b0;
        rdy1 = 1'b0;
        chk("stream_count", nrx, 10);
        for (int i = 0; i < nrx; i++) chk($sformatf("stream_word%0d", i), rx[i], i);
        @(posedge clock); #1;
        chk("stream_empty", v1, 0);
`ifdef ASYNC_TO_SYNC_STATUS_EN
        chk("stream_xfer_cnt", xc1, 10);
        chk("stream_level", lvl1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
